// File: rtl/vga_key_overlay.sv
// VGA timing generator with a per-key highlight overlay for the piano display.
// Pixel coordinates go out to the background path; its BGR returns BG_LAT clocks later and is optionally replaced.
module vga_key_overlay #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int N_KEYS      = 7,
  parameter int KEY_W       = 91,
  parameter int HOLD_FRAMES = 4,
  parameter int BG_LAT      = 2
) (
  input  logic              iVGA_CLK,
  input  logic              iRST_n,
  input  logic [N_KEYS-1:0] key_i,
  output logic [9:0]        pix_x,
  output logic [9:0]        pix_y,
  input  logic [23:0]       bg_bgr,
  output logic              oHS,
  output logic              oVS,
  output logic              oBLANK_n,
  output logic [7:0]        r_data,
  output logic [7:0]        g_data,
  output logic [7:0]        b_data,
  output logic              frame_tick
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int LAST    = BG_LAT - 1;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_BEG   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [9:0] V_TICK   = 10'(V_ACTIVE - 1);
  localparam logic [9:0] COL_LAST = 10'(KEY_W - 1);
  localparam logic [3:0] KEY_NONE = 4'(N_KEYS);
  localparam logic [3:0] HOLD_MAX = 4'(HOLD_FRAMES);

  logic [9:0] hcnt, vcnt, col_cnt;
  logic [3:0] key_idx;
  logic       act_p0, hs_p0, vs_p0, hit_p0;
  logic [2:0] key_p0;
  logic       act_pipe [BG_LAT];
  logic       hs_pipe  [BG_LAT];
  logic       vs_pipe  [BG_LAT];
  logic       hit_pipe [BG_LAT];
  logic [2:0] key_pipe [BG_LAT];
  logic [3:0] hold [N_KEYS];
  logic [7:0] lit_ext;

  function automatic logic [7:0] key_red(input logic [2:0] k);
    return 8'hFF - {k, 5'b0};
  endfunction

  function automatic logic [7:0] key_blue(input logic [2:0] k);
    return {k, 5'b0};
  endfunction

  // key_idx tracks hcnt / KEY_W with a running column counter and saturates at "no key"
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      hcnt    <= '0;
      vcnt    <= '0;
      col_cnt <= '0;
      key_idx <= '0;
    end else if (hcnt == H_LAST) begin
      hcnt    <= '0;
      col_cnt <= '0;
      key_idx <= '0;
      vcnt    <= (vcnt == V_LAST) ? 10'd0 : vcnt + 10'd1;
    end else begin
      hcnt <= hcnt + 10'd1;
      if (col_cnt == COL_LAST) begin
        col_cnt <= '0;
        if (key_idx != KEY_NONE) key_idx <= key_idx + 4'd1;
      end else begin
        col_cnt <= col_cnt + 10'd1;
      end
    end
  end

  assign frame_tick = (hcnt == H_LAST) && (vcnt == V_TICK);

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      for (int k = 0; k < N_KEYS; k++) hold[k] <= '0;
    end else if (frame_tick) begin
      for (int k = 0; k < N_KEYS; k++) begin
        if (key_i[k])             hold[k] <= HOLD_MAX;
        else if (hold[k] != 4'd0) hold[k] <= hold[k] - 4'd1;
      end
    end
  end

  always_comb begin
    lit_ext = '0;
    for (int k = 0; k < N_KEYS; k++) lit_ext[k] = (hold[k] != 4'd0);
  end

  // ---- stage 0: registered pixel address and raw timing
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      pix_x  <= '0;
      pix_y  <= '0;
      act_p0 <= 1'b0;
      hs_p0  <= 1'b1;
      vs_p0  <= 1'b1;
      hit_p0 <= 1'b0;
      key_p0 <= '0;
    end else begin
      pix_x  <= hcnt;
      pix_y  <= vcnt;
      act_p0 <= (hcnt < H_ACT) && (vcnt < V_ACT);
      hs_p0  <= !((hcnt >= HS_BEG) && (hcnt <= HS_END));
      vs_p0  <= !((vcnt >= VS_BEG) && (vcnt <= VS_END));
      hit_p0 <= key_idx < KEY_NONE;
      key_p0 <= key_idx[2:0];
    end
  end

  // ---- stages 1..BG_LAT: wait for the background pixel
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      for (int i = 0; i < BG_LAT; i++) begin
        act_pipe[i] <= 1'b0;
        hs_pipe[i]  <= 1'b1;
        vs_pipe[i]  <= 1'b1;
        hit_pipe[i] <= 1'b0;
        key_pipe[i] <= '0;
      end
    end else begin
      act_pipe[0] <= act_p0;
      hs_pipe[0]  <= hs_p0;
      vs_pipe[0]  <= vs_p0;
      hit_pipe[0] <= hit_p0;
      key_pipe[0] <= key_p0;
      for (int i = 1; i < BG_LAT; i++) begin
        act_pipe[i] <= act_pipe[i-1];
        hs_pipe[i]  <= hs_pipe[i-1];
        vs_pipe[i]  <= vs_pipe[i-1];
        hit_pipe[i] <= hit_pipe[i-1];
        key_pipe[i] <= key_pipe[i-1];
      end
    end
  end

  // ---- output stage: colour select, sync aligned with colour
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      oHS      <= 1'b1;
      oVS      <= 1'b1;
      oBLANK_n <= 1'b0;
      r_data   <= '0;
      g_data   <= '0;
      b_data   <= '0;
    end else begin
      oHS      <= hs_pipe[LAST];
      oVS      <= vs_pipe[LAST];
      oBLANK_n <= act_pipe[LAST];
      if (!act_pipe[LAST]) begin
        r_data <= '0;
        g_data <= '0;
        b_data <= '0;
      end else if (hit_pipe[LAST] && lit_ext[key_pipe[LAST]]) begin
        r_data <= key_red(key_pipe[LAST]);
        g_data <= 8'h00;
        b_data <= key_blue(key_pipe[LAST]);
      end else begin
        {b_data, g_data, r_data} <= bg_bgr;
      end
    end
  end

endmodule

// File: tb/tb_vga_key_overlay.sv
// Directed bench for vga_key_overlay on a reduced 56x16 raster with 5-pixel keys.
module tb_vga_key_overlay;

  localparam int HT = 56;
  localparam int VT = 16;
  localparam int FR = HT * VT;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  key = '0;
  logic [9:0]  pix_x, pix_y;
  logic [23:0] bg_bgr, bg_d1;
  logic        hs, vs, blank_n, tick;
  logic [7:0]  r, g, b;

  int errors = 0;
  int checks = 0;

  vga_key_overlay #(
    .H_ACTIVE(40), .H_FP(4), .H_SYNC(8), .H_BP(4),
    .V_ACTIVE(10), .V_FP(2), .V_SYNC(2), .V_BP(2),
    .N_KEYS(7), .KEY_W(5), .HOLD_FRAMES(4), .BG_LAT(2)
  ) dut (
    .iVGA_CLK(clk), .iRST_n(rst_n), .key_i(key),
    .pix_x(pix_x), .pix_y(pix_y), .bg_bgr(bg_bgr),
    .oHS(hs), .oVS(vs), .oBLANK_n(blank_n),
    .r_data(r), .g_data(g), .b_data(b), .frame_tick(tick)
  );

  always #5 clk = ~clk;

  // Background stub ROM with two clocks of latency
  always @(posedge clk) begin
    bg_d1  <= {8'h00, pix_y[7:0], pix_x[7:0]};
    bg_bgr <= bg_d1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] red_of(input int k);
    case (k)
      0: return 8'hFF;
      1: return 8'hDF;
      2: return 8'hBF;
      3: return 8'h9F;
      4: return 8'h7F;
      5: return 8'h5F;
      default: return 8'h3F;
    endcase
  endfunction

  // {hs, vs, blank_n, r, g, b} expected for raster position (x, y)
  function automatic logic [31:0] exp_out(input int x, input int y, input logic [6:0] mask);
    logic ehs, evs, eact;
    logic [7:0] er, eg, eb;
    ehs  = !(x >= 44 && x <= 51);
    evs  = !(y >= 12 && y <= 13);
    eact = (x < 40) && (y < 10);
    er = 8'h00; eg = 8'h00; eb = 8'h00;
    if (eact) begin
      if (x < 35 && mask[x / 5]) begin
        er = red_of(x / 5);
        eb = 8'hFF - er;
      end else begin
        er = 8'(x);
        eg = 8'(y);
      end
    end
    return {5'b0, ehs, evs, eact, er, eg, eb};
  endfunction

  function automatic logic [31:0] got_out();
    return {5'b0, hs, vs, blank_n, r, g, b};
  endfunction

  task automatic chk_reset_outputs(input string tag);
    chk(tag, got_out(), {5'b0, 3'b110, 24'h0});
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("post_release", got_out(), {5'b0, 3'b110, 24'h0});
    end
  endtask

  // One output frame from pixel (0,0); key_i is presented around the frame tick and optionally pulsed mid-frame
  task automatic run_frame(input string tag, input logic [6:0] mask, input logic [6:0] tick_keys,
                           input bit pulse6, input int stop_y);
    int x, y, q;
    for (int p = 0; p < FR; p++) begin
      x = p % HT;
      y = p / HT;
      if (y == stop_y && x == 10) return;
      @(posedge clk); #1;
      chk(tag, got_out(), exp_out(x, y, mask));
      q = (p + 3) % FR;
      chk({tag, "_addr"}, {11'b0, tick, pix_x, pix_y},
          {11'b0, ((p + 4) % FR) == 559, 10'(q % HT), 10'(q / HT)});
      key = '0;
      if (p >= 550 && p <= 560) key = tick_keys;
      if (pulse6 && p >= 100 && p < 110) key[6] = 1'b1;
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("in_reset");
    chk("in_reset_addr", {11'b0, tick, pix_x, pix_y}, 32'h0);
    release_reset();

    run_frame("f0_bg",      7'b0000000, 7'b0000100, 1'b0, -1);
    run_frame("f1_key2",    7'b0000100, 7'b0000000, 1'b0, -1);
    run_frame("f2_key2",    7'b0000100, 7'b0000000, 1'b0, -1);
    run_frame("f3_key2",    7'b0000100, 7'b0000000, 1'b0, -1);
    run_frame("f4_key2",    7'b0000100, 7'b0000000, 1'b0, -1);
    run_frame("f5_expired", 7'b0000000, 7'b0000000, 1'b1, -1);
    run_frame("f6_nopulse", 7'b0000000, 7'b1000001, 1'b0, -1);
    run_frame("f7_k0k6",    7'b1000001, 7'b0000100, 1'b0, -1);
    run_frame("f8_partial", 7'b1000101, 7'b0000000, 1'b0, 5);

    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("async_reset");
    chk("async_reset_addr", {11'b0, tick, pix_x, pix_y}, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("held_reset");
    release_reset();

    run_frame("f9_after_rst", 7'b0000000, 7'b0000000, 1'b0, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
